// File: rtl/des_key_schedule.sv
// Iterative DES key schedule: PC-1 on key load, per-round C/D rotation, registered PC-2 subkey out.
// Latency: key accepted at edge N gives K1 (or K16 when decrypting) valid in cycle N+1; one subkey per cycle.
// Backpressure: subkey/sk_round/sk_last hold while sk_valid && !sk_ready; no key accepted until the schedule ends.
// Optional build macro DES_DECRYPT_ORDER_EN adds a 'decrypt' input selecting K16..K1 order.
module des_key_schedule (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key,
  input  logic        key_valid,
`ifdef DES_DECRYPT_ORDER_EN
  input  logic        decrypt,
`endif
  output logic        key_ready,
  output logic [47:0] subkey,
  output logic [3:0]  sk_round,
  output logic        sk_valid,
  output logic        sk_last,
  input  logic        sk_ready
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // PC-1: output bit t (1-based) takes DES key bit pc1Map[t-1]; C is bits 1..28, D is bits 29..56.
  localparam int pc1Map [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // PC-2: subkey bit t (1-based) takes CD bit pc2Map[t-1].
  localparam int pc2Map [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-pc1Map[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-pc2Map[i]];
    return r;
  endfunction

  // Rounds 1, 2, 9 and 16 (indices 0, 1, 8, 15) shift by one, all others by two.
  function automatic logic singleShift(input logic [3:0] r);
    return (r == 4'd0) || (r == 4'd1) || (r == 4'd8) || (r == 4'd15);
  endfunction

  function automatic logic [27:0] rotLeft(input logic [27:0] x, input logic single);
    return single ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
  endfunction

`ifdef DES_DECRYPT_ORDER_EN
  function automatic logic [27:0] rotRight(input logic [27:0] x, input logic single);
    return single ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
  endfunction
`endif

  logic [0:0]  state;
  logic [27:0] cHalf, dHalf;
  logic [3:0]  roundCnt;
  logic [47:0] subkeyReg;
  logic [55:0] pc1Key;
  logic [27:0] cNext, dNext;
  logic [3:0]  cntNext;
  logic        lastRound;
  logic        advance;
  logic        unusedParity;

`ifdef DES_DECRYPT_ORDER_EN
  logic        decMode;
`endif

  // Parity bits (DES bits 8,16,...,64) are dropped by PC-1 and never used.
  assign unusedParity = ^{key[56], key[48], key[40], key[32], key[24], key[16], key[8], key[0]};

  assign pc1Key = pc1(key);

`ifdef DES_DECRYPT_ORDER_EN
  assign lastRound = decMode ? (roundCnt == 4'd0) : (roundCnt == 4'd15);
`else
  assign lastRound = (roundCnt == 4'd15);
`endif

  // C/D and the counter move on key load, or on each handshake that is not the final one.
  assign advance = (state == IDLE) ? key_valid : (sk_ready && !lastRound);

  // Next C/D/counter: load with the round-1 rotation, or step to the following round.
  always_comb begin
    cNext   = cHalf;
    dNext   = dHalf;
    cntNext = roundCnt;
    if (state == IDLE) begin
      cNext   = rotLeft(pc1Key[55:28], 1'b1);
      dNext   = rotLeft(pc1Key[27:0], 1'b1);
      cntNext = 4'd0;
`ifdef DES_DECRYPT_ORDER_EN
      // C0,D0 equals C16,D16, so decrypt order starts from the unrotated halves.
      if (decrypt) begin
        cNext   = pc1Key[55:28];
        dNext   = pc1Key[27:0];
        cntNext = 4'd15;
      end
`endif
    end else begin
      cNext   = rotLeft(cHalf, singleShift(roundCnt + 4'd1));
      dNext   = rotLeft(dHalf, singleShift(roundCnt + 4'd1));
      cntNext = roundCnt + 4'd1;
`ifdef DES_DECRYPT_ORDER_EN
      // Walking backwards undoes the current round's left shift.
      if (decMode) begin
        cNext   = rotRight(cHalf, singleShift(roundCnt));
        dNext   = rotRight(dHalf, singleShift(roundCnt));
        cntNext = roundCnt - 4'd1;
      end
`endif
    end
  end

  // State, C/D halves, round counter and the PC-2 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cHalf     <= '0;
      dHalf     <= '0;
      roundCnt  <= '0;
      subkeyReg <= '0;
`ifdef DES_DECRYPT_ORDER_EN
      decMode   <= 1'b0;
`endif
    end else begin
      if (advance) begin
        cHalf     <= cNext;
        dHalf     <= dNext;
        roundCnt  <= cntNext;
        subkeyReg <= pc2({cNext, dNext});
      end
      if (state == IDLE && key_valid) begin
        state <= RUN;
`ifdef DES_DECRYPT_ORDER_EN
        decMode <= decrypt;
`endif
      end else if (state == RUN && sk_ready && lastRound) begin
        state <= IDLE;
      end
    end
  end

  assign key_ready = (state == IDLE);
  assign sk_valid  = (state == RUN);
  assign subkey    = subkeyReg;
  assign sk_round  = roundCnt;
  assign sk_last   = sk_valid && lastRound;

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomised bench for des_key_schedule with an in-bench reference of the DES key schedule.
// The reference derives each subkey directly from the key via cumulative shift counts.
// A negedge compare process checks every output on every cycle.
module tb_des_key_schedule;

  localparam logic [63:0] GOLD  = 64'h133457799BBCDFF1;
  localparam logic [63:0] PFLIP = 64'h123556789ABDDEF0;
  localparam logic [63:0] PMASK = 64'hFEFEFEFEFEFEFEFE;

  logic        clk;
  logic        rst_n;
  logic [63:0] key;
  logic        key_valid;
  logic        decrypt;
  logic        key_ready;
  logic [47:0] subkey;
  logic [3:0]  sk_round;
  logic        sk_valid;
  logic        sk_last;
  logic        sk_ready;

  int errors = 0;
  int checks = 0;

  des_key_schedule dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key      (key),
    .key_valid(key_valid),
`ifdef DES_DECRYPT_ORDER_EN
    .decrypt  (decrypt),
`endif
    .key_ready(key_ready),
    .subkey   (subkey),
    .sk_round (sk_round),
    .sk_valid (sk_valid),
    .sk_last  (sk_last),
    .sk_ready (sk_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pc1T [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                    63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2T [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                    41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int shiftT [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  // Subkey K<kNum> straight from the key: CD_i bit p is CD_0 bit p shifted by the cumulative count.
  function automatic logic [47:0] refSubkey(input logic [63:0] k, input int kNum);
    int cum, p, pos, src;
    logic [47:0] r;
    cum = 0;
    r = '0;
    for (int i = 0; i < kNum; i++) cum += shiftT[i];
    for (int j = 0; j < 48; j++) begin
      p = pc2T[j];
      if (p <= 28) pos = (p - 1 + cum) % 28;
      else         pos = 28 + (p - 29 + cum) % 28;
      src = pc1T[pos];
      r[47-j] = k[64-src];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference transaction state: which key, which direction, how many subkeys already consumed.
  bit          mRun = 1'b0;
  int          mIdx = 0;
  logic [63:0] mKey = '0;
  bit          mDec = 1'b0;
  int          dutFires = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mRun <= 1'b0;
      mIdx <= 0;
    end else begin
      if (sk_valid && sk_ready) dutFires <= dutFires + 1;
      if (!mRun) begin
        if (key_valid) begin
          mRun <= 1'b1;
          mIdx <= 0;
          mKey <= key;
`ifdef DES_DECRYPT_ORDER_EN
          mDec <= decrypt;
`else
          mDec <= 1'b0;
`endif
        end
      end else if (sk_ready) begin
        mIdx <= mIdx + 1;
        if (mIdx == 15) mRun <= 1'b0;
      end
    end
  end

  // Compare process: pins the reference with known subkeys, then checks every output each negedge.
  initial begin
    int kNum;
    check("ref_K1",  refSubkey(GOLD, 1),  48'h1B02EFFC7072);
    check("ref_K2",  refSubkey(GOLD, 2),  48'h79AED9DBC9E5);
    check("ref_K16", refSubkey(GOLD, 16), 48'hCB3D8B0E17F5);
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_sk_valid",  sk_valid,  0);
        check("rst_key_ready", key_ready, 1);
        check("rst_subkey",    subkey,    0);
        check("rst_sk_round",  sk_round,  0);
        check("rst_sk_last",   sk_last,   0);
      end else begin
        check("key_ready", key_ready, !mRun);
        check("sk_valid",  sk_valid,  mRun);
        if (mRun) begin
          kNum = mDec ? (16 - mIdx) : (mIdx + 1);
          check("sk_round", sk_round, kNum - 1);
          check("subkey",   subkey,   refSubkey(mKey, kNum));
          check("sk_last",  sk_last,  mIdx == 15);
          if ((mKey & PMASK) == (GOLD & PMASK)) begin
            if (sk_round == 4'd0)  check("gold_K1",  subkey, 48'h1B02EFFC7072);
            if (sk_round == 4'd15) check("gold_K16", subkey, 48'hCB3D8B0E17F5);
          end
        end else begin
          check("idle_sk_last", sk_last, 0);
        end
      end
    end
  end

  // One full schedule: present the key, drive sk_ready, optionally pulse a rogue key mid-run.
  task automatic runSchedule(input logic [63:0] k, input bit dec, input bit randReady, input bit pulseBad);
    int f0;
    int c;
    bit done;
    c = 0;
    while (c < 50 && !key_ready) begin
      @(posedge clk); #1;
      c++;
    end
    check("key_ready_before_load", key_ready, 1);
    f0 = dutFires;
    key = k;
    key_valid = 1'b1;
    decrypt = dec;
    sk_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    key = {$urandom, $urandom};
    decrypt = 1'($urandom_range(0, 1));
    done = 1'b0;
    c = 0;
    while (c < 400 && !done) begin
      sk_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      key_valid = pulseBad && (c >= 3) && (c <= 5);
      if (key_valid) key = 64'hFFFFFFFFFFFFFFFF;
      @(posedge clk); #1;
      done = key_ready;
      c++;
    end
    key_valid = 1'b0;
    check("schedule_done", done, 1);
    check("transfers", dutFires - f0, 16);
  endtask

  initial begin
    int c;
    rst_n = 1'b0;
    key = '0;
    key_valid = 1'b0;
    decrypt = 1'b0;
    sk_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Full-rate encrypt schedule, then the same key under random backpressure.
    runSchedule(GOLD, 1'b0, 1'b0, 1'b0);
    runSchedule(GOLD, 1'b0, 1'b1, 1'b0);
    // A key offered during RUN must be ignored.
    runSchedule(GOLD, 1'b0, 1'b0, 1'b1);
    runSchedule(GOLD, 1'b0, 1'b1, 1'b1);
    // Parity bits must not matter.
    runSchedule(PFLIP, 1'b0, 1'b0, 1'b0);
    // Random keys.
    for (int n = 0; n < 6; n++) runSchedule({$urandom, $urandom}, 1'b0, 1'($urandom_range(0, 1)), 1'b0);

    // Reset asserted asynchronously in the middle of the schedule (round 5).
    key = GOLD;
    key_valid = 1'b1;
    sk_ready = 1'b1;
    @(posedge clk); #1;
    key_valid = 1'b0;
    c = 0;
    while (c < 40 && !(sk_valid && sk_round == 4'd5)) begin
      @(posedge clk); #1;
      c++;
    end
    check("reached_round5", sk_round, 5);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    runSchedule(GOLD, 1'b0, 1'b0, 1'b0);
    runSchedule({$urandom, $urandom}, 1'b0, 1'b1, 1'b0);

`ifdef DES_DECRYPT_ORDER_EN
    runSchedule(GOLD, 1'b1, 1'b0, 1'b0);
    runSchedule(GOLD, 1'b1, 1'b1, 1'b1);
    runSchedule(PFLIP, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 4; n++) runSchedule({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
`endif

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
